feature_mem_loader: RTL and testbench
=====================================

Name: feature_mem_loader

Overview:
- Write-side sequencer for the Tn-group x KERNEL_SIZE-line scratchpad feature memory.
- Accepts a valid/ready stream of DATA_BUS_WIDTH words and turns it into the memory's write strobe, group select, line select and data.
- Sits between the DDR/stream fetch path and the feature memory. Supports a full tile fill and a single-line refill (line-buffer mode).

Parameters:
Tn, `Tn, number of memory groups (input channels); 1..16
KERNEL_SIZE, `KERNEL_SIZE, lines per group; 1..16
DATA_BUS_WIDTH, `DATA_BUS_WIDTH, stream and write-data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse, begin a load
mode  in  1  0 = full fill, 1 = single-line refill; sampled on start
line_sel  in  4  target line for mode 1; sampled on start
s_data  in  DATA_BUS_WIDTH  stream data
s_valid  in  1  stream valid
s_ready  out  1  stream ready
wr_en  out  1  feature memory write strobe
wr_mem_group  out  4  group index
wr_mem_line  out  4  line index
o_port  out  DATA_BUS_WIDTH  write data
busy  out  1  load in progress
done  out  1  one-cycle pulse, load finished
err  out  1  one-cycle pulse, start rejected
stall_cnt  out  16  see Optional Feature

Behaviour:
- Reset (rst low, asynchronous) clears all outputs to 0, the FSM to IDLE and the counters to 0. Reset may hit mid-load: the load is abandoned, no done pulse follows, and the memory contents are undefined.
- FSM states: IDLE, LOAD, FINISH.
- IDLE -> LOAD on start. busy goes to 1 the next cycle.
- Exception: start with mode=1 and line_sel >= KERNEL_SIZE goes to no state change; err pulses the next cycle.
- In IDLE, err and done are never asserted together.
- A start pulse during LOAD or FINISH is ignored; err is not asserted for it.
- s_ready = 1 exactly when the state is LOAD. A beat is accepted on a cycle with s_valid && s_ready.
- Write outputs are registered. An accepted beat produces wr_en=1 the following cycle, together with o_port = s_data and the current group/line indices.
- On a cycle with no accepted beat, wr_en=0, o_port=0, and group/line hold their values.
- The feature memory adds its own register stage, so the data is resident 2 cycles after acceptance.
- Mode 0 order is group-major, Tn*KERNEL_SIZE beats: (g0,l0)..(g0,l K-1), (g1,l0)... Line wraps from K-1 to 0 and increments the group.
- Mode 1: Tn beats, groups 0..Tn-1, line fixed at line_sel.
- On the last accepted beat, LOAD -> FINISH and s_ready drops in the following cycle; no extra beat is taken.
- FINISH: the final wr_en is issued; done pulses the next cycle, busy drops on the same cycle as done, and the FSM returns to IDLE.
- Latency from the last accepted beat to done is 2 cycles.
- s_valid gaps of any length are legal. The counters advance only on accepted beats.
- Count widths are 4 bits each. Tn=16 and KERNEL_SIZE=16 reach index 15 with no overflow.

Optional Feature:
- Macro: FEATURE_LOADER_STALL_CNT_EN.
- Defined: stall_cnt counts cycles in LOAD with s_valid=0. It saturates at 16'hFFFF, clears on each accepted start, and holds its value in IDLE.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Shared header network_para.vh: Tn, KERNEL_SIZE and DATA_BUS_WIDTH macros, plus the FSM encoding localparams LDR_IDLE=2'd0, LDR_LOAD=2'd1, LDR_FINISH=2'd2 so the read-side controller can reuse them.
- One sub-module, loader_addr_gen, holds the group/line counters. Its interface: step, mode, line_sel, load, and last-beat flag.

Test Plan:
- Tn=4, K=3, mode 0, 12 back-to-back beats with data 0..11 -> wr_en on 12 consecutive cycles; (group,line) = (0,0),(0,1),(0,2),(1,0)..(3,2); o_port = 0..11; done 2 cycles after the 12th accept; busy falls with done.
- Same stimulus with s_valid low every other cycle -> same write sequence with gaps, wr_en=0 in the gaps, done 2 cycles after the last accept.
- mode 1, line_sel=2 -> 4 writes at (0,2),(1,2),(2,2),(3,2); a 5th valid beat is not accepted (s_ready=0).
- mode 1, line_sel=5 with K=3 -> err pulse, busy stays 0, no wr_en.
- start pulsed again at beat 5 of a mode 0 load -> ignored; exactly 12 writes, one done.
- rst low after beat 6 -> all outputs 0 immediately, no done; a new start then loads 12 beats correctly.
- With FEATURE_LOADER_STALL_CNT_EN: 7 idle-valid cycles during LOAD -> stall_cnt=7.

Source files
------------

// File: rtl/feature_mem_loader_pkg.sv
// rtl/feature_mem_loader_pkg.sv - shared loader geometry defaults and FSM encoding
package feature_mem_loader_pkg;

  localparam int DEF_TN             = 4;
  localparam int DEF_KERNEL_SIZE    = 3;
  localparam int DEF_DATA_BUS_WIDTH = 32;

  // Encoding is shared with the read-side controller, so values are pinned.
  typedef enum logic [1:0] {
    LDR_IDLE   = 2'd0,
    LDR_LOAD   = 2'd1,
    LDR_FINISH = 2'd2
  } ldr_state_t;

endpackage

// File: rtl/feature_mem_loader_addr_gen.sv
// rtl/feature_mem_loader_addr_gen.sv - group/line counters for the feature memory write side
module loader_addr_gen
  import feature_mem_loader_pkg::*;
#(
  parameter int Tn          = DEF_TN,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       mode,
  input  logic [3:0] line_sel,
  input  logic       step,
  output logic [3:0] group,
  output logic [3:0] line,
  output logic       last
);

  localparam logic [3:0] LAST_GROUP = 4'(Tn - 1);
  localparam logic [3:0] LAST_LINE  = 4'(KERNEL_SIZE - 1);

  logic mode_q;

  assign last = (group == LAST_GROUP) && (mode_q || (line == LAST_LINE));

  // Indices always describe the beat about to be accepted; the final beat does not advance them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      group  <= '0;
      line   <= '0;
      mode_q <= 1'b0;
    end else if (load) begin
      group  <= '0;
      line   <= mode ? line_sel : 4'd0;
      mode_q <= mode;
    end else if (step && !last) begin
      if (mode_q) begin
        group <= group + 4'd1;
      end else if (line == LAST_LINE) begin
        line  <= '0;
        group <= group + 4'd1;
      end else begin
        line <= line + 4'd1;
      end
    end
  end

endmodule

// File: rtl/feature_mem_loader.sv
// rtl/feature_mem_loader.sv - stream-to-feature-memory write sequencer; optional FEATURE_LOADER_STALL_CNT_EN
module feature_mem_loader
  import feature_mem_loader_pkg::*;
#(
  parameter int Tn             = DEF_TN,
  parameter int KERNEL_SIZE    = DEF_KERNEL_SIZE,
  parameter int DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic [3:0]                line_sel,
  input  logic [DATA_BUS_WIDTH-1:0] s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic                      wr_en,
  output logic [3:0]                wr_mem_group,
  output logic [3:0]                wr_mem_line,
  output logic [DATA_BUS_WIDTH-1:0] o_port,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [15:0]               stall_cnt
);

  localparam logic [4:0] K_LINES = 5'(KERNEL_SIZE);

  ldr_state_t state, state_nxt;
  logic       accept, start_ok, bad_line;
  logic       busy_nxt, done_nxt, err_nxt;
  logic [3:0] cur_group, cur_line;
  logic       last_beat;

  assign bad_line = mode && ({1'b0, line_sel} >= K_LINES);
  assign accept   = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LDR_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LDR_IDLE:   if (start && !bad_line) state_nxt = LDR_LOAD;
      LDR_LOAD:   if (accept && last_beat) state_nxt = LDR_FINISH;
      LDR_FINISH: state_nxt = LDR_IDLE;
      default:    state_nxt = LDR_IDLE;
    endcase
  end

  always_comb begin
    s_ready  = (state == LDR_LOAD);
    start_ok = (state == LDR_IDLE) && start && !bad_line;
    err_nxt  = (state == LDR_IDLE) && start && bad_line;
    done_nxt = (state == LDR_FINISH);
    busy_nxt = (state == LDR_IDLE) ? start_ok : (state == LDR_LOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      err  <= err_nxt;
    end
  end

  loader_addr_gen #(
    .Tn          (Tn),
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .mode     (mode),
    .line_sel (line_sel),
    .step     (accept),
    .group    (cur_group),
    .line     (cur_line),
    .last     (last_beat)
  );

  // Group/line hold across idle cycles so the memory sees stable addresses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en        <= 1'b0;
      wr_mem_group <= '0;
      wr_mem_line  <= '0;
      o_port       <= '0;
    end else begin
      wr_en  <= accept;
      o_port <= accept ? s_data : '0;
      if (accept) begin
        wr_mem_group <= cur_group;
        wr_mem_line  <= cur_line;
      end
    end
  end

`ifdef FEATURE_LOADER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if ((state == LDR_LOAD) && !s_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_feature_mem_loader.sv
// tb/tb_feature_mem_loader.sv - scoreboard bench for feature_mem_loader (Tn=4, K=3)
module tb_feature_mem_loader;
  import feature_mem_loader_pkg::*;

  localparam int TN = 4;
  localparam int K  = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [3:0]    line_sel = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready, wr_en, busy, done, err;
  logic [3:0]    wr_mem_group, wr_mem_line;
  logic [DW-1:0] o_port;
  logic [15:0]   stall_cnt;

  typedef struct {
    logic [3:0]  g;
    logic [3:0]  l;
    logic [31:0] d;
  } wr_t;

  wr_t q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  last_acc = 0;
  int  done_count = 0;
  int  err_count = 0;
  int  wr_count = 0;

  feature_mem_loader #(.Tn(TN), .KERNEL_SIZE(K), .DATA_BUS_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .mode         (mode),
    .line_sel     (line_sel),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .wr_en        (wr_en),
    .wr_mem_group (wr_mem_group),
    .wr_mem_line  (wr_mem_line),
    .o_port       (o_port),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst && wr_en) begin
      wr_count++;
      if (q.size() == 0) begin
        chk("unexpected_wr", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_group", 32'(wr_mem_group), 32'(e.g));
        chk("wr_line", 32'(wr_mem_line), 32'(e.l));
        chk("wr_data", o_port, e.d);
      end
    end
    if (rst && !wr_en && o_port != '0) chk("oport_idle", o_port, 32'd0);
    if (rst && done) begin
      done_count++;
      chk("done_latency", 32'(cyc - last_acc), 32'd2);
      chk("busy_at_done", 32'(busy), 32'd0);
    end
    if (rst && err) err_count++;
  end

  task automatic do_start(input logic m, input logic [3:0] ls);
    start = 1'b1;
    mode = m;
    line_sel = ls;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives n beats; returns early after rst_after accepted beats (0 = never).
  task automatic load_beats(input int n, input logic m, input logic [3:0] ls, input logic [31:0] base,
                            input bit gaps, input int restart_at, input int rst_after);
    for (int i = 0; i < n; i++) begin
      int tmo;
      wr_t e;
      s_valid = 1'b1;
      s_data = base + 32'(i);
      if (i == restart_at) begin
        start = 1'b1;
        mode = 1'b0;
        line_sel = 4'd0;
      end
      tmo = 0;
      forever begin
        @(negedge clk);
        if (s_ready) break;
        tmo++;
        if (tmo > 50) begin
          chk("ready_timeout", 32'd0, 32'd1);
          s_valid = 1'b0;
          start = 1'b0;
          return;
        end
      end
      e.g = m ? 4'(i) : 4'(i / K);
      e.l = m ? ls : 4'(i % K);
      e.d = s_data;
      q.push_back(e);
      last_acc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      s_valid = 1'b0;
      if (gaps) begin
        @(posedge clk); #1;
      end
      if (i + 1 == rst_after) return;
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_count < target && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_count", 32'(done_count), 32'(target));
    chk("queue_drained", 32'(q.size()), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int wr0;
    int err0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_oport", o_port, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_err", 32'(err), 32'd0);
    chk("idle_stall", 32'(stall_cnt), 32'd0);

    // full fill, back-to-back
    wr0 = wr_count;
    do_start(1'b0, 4'd0);
    chk("busy_after_start", 32'(busy), 32'd1);
    load_beats(TN * K, 1'b0, 4'd0, 32'd0, 1'b0, -1, 0);
    wait_done(1);
    chk("fill_writes", 32'(wr_count - wr0), 32'(TN * K));

    // full fill with gaps
    wr0 = wr_count;
    do_start(1'b0, 4'd0);
    load_beats(TN * K, 1'b0, 4'd0, 32'h100, 1'b1, -1, 0);
    wait_done(2);
    chk("gap_writes", 32'(wr_count - wr0), 32'(TN * K));
`ifndef FEATURE_LOADER_STALL_CNT_EN
    chk("stall_tied_off", 32'(stall_cnt), 32'd0);
`endif

    // single-line refill, then an extra beat that must not be taken
    wr0 = wr_count;
    do_start(1'b1, 4'd2);
    load_beats(TN, 1'b1, 4'd2, 32'hA0, 1'b0, -1, 0);
    s_valid = 1'b1;
    s_data = 32'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("extra_beat_ready", 32'(s_ready), 32'd0);
    end
    s_valid = 1'b0;
    wait_done(3);
    chk("refill_writes", 32'(wr_count - wr0), 32'(TN));

    // refill with out-of-range line
    err0 = err_count;
    do_start(1'b1, 4'd5);
    chk("bad_line_err", 32'(err), 32'd1);
    chk("bad_line_busy", 32'(busy), 32'd0);
    chk("bad_line_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    chk("bad_line_err_pulse", 32'(err), 32'd0);
    chk("bad_line_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    chk("bad_line_err_total", 32'(err_count - err0), 32'd1);

    // start re-pulsed mid-load is ignored
    err0 = err_count;
    wr0 = wr_count;
    do_start(1'b0, 4'd0);
    load_beats(TN * K, 1'b0, 4'd0, 32'h200, 1'b0, 5, 0);
    wait_done(4);
    chk("restart_writes", 32'(wr_count - wr0), 32'(TN * K));
    chk("restart_no_err", 32'(err_count - err0), 32'd0);
    chk("restart_idle", 32'(busy), 32'd0);

    // reset mid-load
    do_start(1'b0, 4'd0);
    load_beats(TN * K, 1'b0, 4'd0, 32'h300, 1'b0, -1, 6);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    chk("midrst_group", 32'(wr_mem_group), 32'd0);
    chk("midrst_line", 32'(wr_mem_line), 32'd0);
    chk("midrst_pending", 32'(q.size()), 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_count), 32'd4);
    wr0 = wr_count;
    do_start(1'b0, 4'd0);
    load_beats(TN * K, 1'b0, 4'd0, 32'h400, 1'b0, -1, 0);
    wait_done(5);
    chk("post_rst_writes", 32'(wr_count - wr0), 32'(TN * K));

`ifdef FEATURE_LOADER_STALL_CNT_EN
    do_start(1'b0, 4'd0);
    chk("stall_cleared", 32'(stall_cnt), 32'd0);
    repeat (7) @(posedge clk);
    #1;
    chk("stall_count", 32'(stall_cnt), 32'd7);
    load_beats(TN * K, 1'b0, 4'd0, 32'h500, 1'b0, -1, 0);
    wait_done(6);
    chk("stall_hold_idle", 32'(stall_cnt), 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
